// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one single-cycle instruction memory between the fetch and loader ports.
// Ties alternate (round-robin). A locked loader may keep fetch waiting for at most MAX_WAIT cycles.
module imem_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        F_Req,
  input  logic [31:0] F_Addr,
  output logic        F_Gnt,
  output logic        F_Valid,
  output logic [31:0] F_Data,
  input  logic        L_Req,
  input  logic        L_We,
  input  logic        L_Lock,
  input  logic [31:0] L_Addr,
  input  logic [31:0] L_WData,
  output logic        L_Gnt,
  output logic        L_Valid,
  output logic [31:0] L_RData,
  output logic [29:0] M_Addr,
  output logic        M_We,
  output logic [31:0] M_WData,
  input  logic [31:0] M_RData
);
  localparam int            CW   = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WMAX = CW'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, LAST_F, LAST_L, LOCK} state_t;

  state_t        state;
  logic [CW-1:0] wcnt;
  logic [29:0]   maddr_q;
  logic          unused_lsb;

  // Memory is word-addressed, so the byte offset does not take part.
  assign unused_lsb = ^{F_Addr[1:0], L_Addr[1:0]};

  always_comb begin
    F_Gnt = 1'b0;
    L_Gnt = 1'b0;
    if (!Rst) begin
      if (state == LOCK && L_Req) begin
        // Lock holds fetch off only until the wait counter reaches its bound.
        if (F_Req && wcnt == WMAX) F_Gnt = 1'b1;
        else                       L_Gnt = 1'b1;
      end else if (F_Req && L_Req) begin
        if (state == LAST_F) L_Gnt = 1'b1;
        else                 F_Gnt = 1'b1;
      end else begin
        F_Gnt = F_Req;
        L_Gnt = L_Req;
      end
    end
  end

  assign M_Addr  = F_Gnt ? F_Addr[31:2] : (L_Gnt ? L_Addr[31:2] : maddr_q);
  assign M_We    = L_Gnt & L_We;
  assign M_WData = L_Gnt ? L_WData : '0;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= IDLE;
      wcnt    <= '0;
      F_Valid <= 1'b0;
      L_Valid <= 1'b0;
      F_Data  <= '0;
      L_RData <= '0;
      maddr_q <= '0;
    end else begin
      if (F_Gnt)      state <= LAST_F;
      else if (L_Gnt) state <= L_Lock ? LOCK : LAST_L;
      else            state <= IDLE;

      F_Valid <= F_Gnt;
      L_Valid <= L_Gnt;
      if (F_Gnt)          F_Data  <= M_RData;
      if (L_Gnt && !L_We) L_RData <= M_RData;
      if (F_Gnt || L_Gnt) maddr_q <= M_Addr;

      // Count only denials that keep the lock; anything else restarts the wait.
      if (state == LOCK && F_Req && L_Gnt && L_Lock)
        wcnt <= (wcnt == WMAX) ? wcnt : wcnt + CW'(1);
      else
        wcnt <= '0;
    end
  end

endmodule
